// File: rtl/spw_ulight_clock_sel_seq.sv
// Avalon-MM clock-select port: switches out_port behind a gated, guard-timed
// sequence (gate off, guard, apply select, guard, gate on) so the link clock mux never glitches.
module spw_ulight_clock_sel_seq #(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned GUARD_W = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter logic [GUARD_W-1:0] GUARD_RESET = GUARD_W'(16)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port,
  output logic             out_en,
  output logic             irq
);

  typedef enum logic [1:0] {IDLE, PRE, POST} state_t;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   target, next_target, out_port_nxt;
  logic [GUARD_W-1:0] guard, cnt, cnt_nxt;
  logic               out_en_nxt, done_set, done, irq_en, wr;
  logic               unused_wd;

  assign wr        = chipselect & ~write_n;
  assign unused_wd = ^writedata;

  always_comb begin
    next_target = target;
    if (wr) begin
      case (address)
        3'd0:    next_target = writedata[WIDTH-1:0];
        3'd4:    next_target = target | writedata[WIDTH-1:0];
        3'd5:    next_target = target & ~writedata[WIDTH-1:0];
        default: next_target = target;
      endcase
    end
  end

  // Selection is compared against the in-flight write so a switch can start,
  // retarget or restart on the very edge the host changes its mind.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    out_port_nxt = out_port;
    out_en_nxt   = out_en;
    done_set     = 1'b0;
    case (state)
      IDLE: begin
        if (next_target != out_port) begin
          state_nxt  = PRE;
          out_en_nxt = 1'b0;
          cnt_nxt    = guard;
        end
      end
      PRE: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - GUARD_W'(1);
        end else begin
          out_port_nxt = next_target;
          cnt_nxt      = guard;
          state_nxt    = POST;
        end
      end
      POST: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - GUARD_W'(1);
        end else if (next_target != out_port) begin
          state_nxt = PRE;
          cnt_nxt   = guard;
        end else begin
          state_nxt  = IDLE;
          out_en_nxt = 1'b1;
          done_set   = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      target   <= RESET_VALUE;
      out_port <= RESET_VALUE;
      out_en   <= 1'b1;
      cnt      <= '0;
      guard    <= GUARD_RESET;
      irq_en   <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      target   <= next_target;
      out_port <= out_port_nxt;
      out_en   <= out_en_nxt;
      cnt      <= cnt_nxt;
      if (wr && address == 3'd2) guard <= writedata[GUARD_W-1:0];
      if (wr && address == 3'd3) irq_en <= writedata[0];
      if (done_set) done <= 1'b1;
      else if (wr && address == 3'd1 && writedata[1]) done <= 1'b0;
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      3'd0: readdata = 32'(target);
      3'd1: readdata = 32'({out_port, 8'h00}) | {30'd0, done, state != IDLE};
      3'd2: readdata = 32'(guard);
      3'd3: readdata = {31'd0, irq_en};
      default: readdata = '0;
    endcase
  end

  assign irq = done & irq_en;

endmodule

// File: tb/tb_spw_ulight_clock_sel_seq.sv
// Scoreboard bench: host writes push expected output events (timed from the
// guard rules); a monitor pops and compares whenever out_port or out_en moves.
module tb_spw_ulight_clock_sel_seq;
  localparam int MASK = 7;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [2:0]  out_port;
  logic        out_en;
  logic        irq;

  spw_ulight_clock_sel_seq #(
    .WIDTH(3), .GUARD_W(8), .RESET_VALUE(3'd0), .GUARD_RESET(8'd16)
  ) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .out_port(out_port), .out_en(out_en), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct {int kind; int cyc; int val;} ev_t;  // kind 0 port, 1 en rise, 2 en fall
  ev_t expq[$];

  int checks = 0, failures = 0, cyc = 0;
  bit mon_off = 1'b1;
  logic [2:0] prev_port;
  logic prev_en;
  int m_target, m_out, m_guard, m_irq_en, m_done;

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic see(input int kind, input int val);
    ev_t e;
    if (expq.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL unexpected_event: got kind=%0d val=%0d at cycle %0d expected none", kind, val, cyc);
    end else begin
      e = expq.pop_front();
      chk("event_kind", kind, e.kind);
      chk("event_cycle", cyc, e.cyc);
      chk("event_val", val, e.val);
    end
  endtask

  always @(negedge clk) begin
    if (!mon_off) begin
      if (out_port !== prev_port) see(0, int'(out_port));
      if (out_en !== prev_en) see(out_en ? 1 : 2, 0);
      prev_port = out_port;
      prev_en = out_en;
    end
  end

  task automatic push(input int kind, input int c, input int val);
    ev_t e;
    e.kind = kind; e.cyc = c; e.val = val;
    expq.push_back(e);
  endtask

  task automatic model_reset();
    m_target = 0; m_out = 0; m_guard = 16; m_irq_en = 0; m_done = 0;
  endtask

  // write lands on edge T (no earlier than 'at'); returns #1 after that edge
  task automatic wr(input int a, input int d, input int at, output int T);
    @(negedge clk);
    while (cyc + 1 < at) @(negedge clk);
    address = a[2:0]; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    T = cyc + 1;
    case (a)
      0: m_target = d & MASK;
      1: if ((d & 2) != 0) m_done = 0;
      2: m_guard = d & 255;
      3: m_irq_en = d & 1;
      4: m_target = (m_target | d) & MASK;
      5: m_target = m_target & ~d & MASK;
      default: ;
    endcase
    @(posedge clk);
    #1;
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd(input int a, input int exp, input string name);
    @(negedge clk);
    address = a[2:0]; chipselect = 1'b1; write_n = 1'b1;
    #1 chk(name, readdata, exp);
    chipselect = 1'b0;
  endtask

  task automatic expect_switch(input int T, input int g, input int v);
    if (v != m_out) begin
      push(2, T, 0);
      push(0, T + g + 1, v);
      push(1, T + 2 * g + 2, 0);
      m_out = v;
      m_done = 1;
    end
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
    chk("queue_drained", expq.size(), 0);
  endtask

  task automatic reset_pulse();
    mon_off = 1'b1;
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_out_port", out_port, 0);
    chk("rst_out_en", out_en, 1);
    chk("rst_irq", irq, 0);
    address = 3'd1;
    #1 chk("rst_status", readdata, 0);
    address = 3'd2;
    #1 chk("rst_guard", readdata, 16);
    @(negedge clk);
    reset_n = 1'b1;
    expq.delete();
    model_reset();
    prev_port = out_port;
    prev_en = out_en;
    mon_off = 1'b0;
  endtask

  initial begin
    #3000000;
    failures++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    int T, T2, g, op, d, a;
    model_reset();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    prev_port = out_port;
    prev_en = out_en;
    mon_off = 1'b0;

    chk("reset_out_port", out_port, 0);
    chk("reset_out_en", out_en, 1);
    chk("reset_irq", irq, 0);
    rd(0, 0, "rd_data");
    rd(1, 0, "rd_status");
    rd(2, 16, "rd_guard");
    rd(3, 0, "rd_irq_en");
    for (int i = 4; i < 8; i++) rd(i, 0, "rd_zero");

    // basic switch with guard 4 and irq
    wr(2, 4, 0, T);
    wr(3, 1, 0, T);
    wr(0, 5, 0, T);
    expect_switch(T, 4, 5);
    rd(1, 1, "status_busy");
    while (cyc < T + 9) @(negedge clk);
    chk("irq_before_done", irq, 0);
    @(negedge clk);
    chk("irq_at_done", irq, 1);
    settle(2);
    rd(1, 32'h502, "status_done");
    wr(1, 2, 0, T);
    chk("irq_cleared", irq, 0);
    rd(1, 32'h500, "status_cleared");

    // same value: no sequence
    wr(0, 5, 0, T);
    rd(1, 32'h500, "status_same_value");
    settle(12);

    // OUTSET then OUTCLR during PRE
    wr(0, 1, 0, T);
    expect_switch(T, 4, 1);
    settle(12);
    wr(4, 2, 0, T);
    push(2, T, 0);
    wr(5, 1, T + 2, T2);
    push(0, T + 5, 2);
    push(1, T + 10, 0);
    m_out = 2; m_done = 1;
    settle(14);
    rd(1, 32'h202, "status_pre_clr");

    // OUTSET then OUTCLR during POST: PRE restarts
    wr(0, 1, 0, T);
    expect_switch(T, 4, 1);
    settle(12);
    wr(4, 2, 0, T);
    push(2, T, 0);
    push(0, T + 5, 3);
    wr(5, 1, T + 7, T2);
    push(0, T + 15, 2);
    push(1, T + 20, 0);
    m_out = 2;
    settle(24);
    rd(0, 2, "target_post_clr");

    // write on the edge PRE reaches zero
    wr(0, 3, 0, T);
    push(2, T, 0);
    wr(0, 6, T + 5, T2);
    push(0, T + 5, 6);
    push(1, T + 10, 0);
    m_out = 6;
    settle(14);

    // reset mid-PRE, then a normal sequence
    wr(2, 16, 0, T);
    wr(0, 3, 0, T);
    push(2, T, 0);
    repeat (3) @(negedge clk);
    reset_pulse();
    wr(0, 3, 0, T);
    expect_switch(T, 16, 3);
    settle(40);

    // reset mid-POST
    wr(0, 5, 0, T);
    expect_switch(T, 16, 5);
    while (cyc < T + 20) @(negedge clk);
    reset_pulse();
    wr(2, 1, 0, T);
    wr(0, 4, 0, T);
    expect_switch(T, 1, 4);
    settle(8);
    rd(1, (4 << 8) | 2, "status_after_reset");

    // randomized host operations
    for (int i = 0; i < 24; i++) begin
      g = $urandom_range(0, 3);
      wr(2, g, 0, T);
      wr(3, $urandom_range(0, 1), 0, T);
      if ($urandom_range(0, 2) == 0) wr(1, 2, 0, T);
      op = $urandom_range(0, 2);
      d = $urandom;
      a = (op == 0) ? 0 : (op == 1) ? 4 : 5;
      wr(a, d, 0, T);
      expect_switch(T, g, m_target);
      settle(2 * g + 4);
      rd(1, (m_out << 8) | (m_done << 1), "rand_status");
      chk("rand_irq", irq, m_done & m_irq_en);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
